// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and checksum helper for the UART frame parser.
//   frame_state_t : parser FSM states
//   SYNC_DEFAULT  : default frame start byte
//   chk_add       : one checksum step, 8-bit wrapping add
package uart_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CHK, ST_HOLD} frame_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic logic [7:0] chk_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: MAX_LEN x 8 payload register file, one write port, one async read port.
//   clk         : write clock
//   we/waddr/wdata : write enable, byte index, byte
//   raddr/rdata : asynchronous read; out-of-range indices read as 0
module uart_frame_buf #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] DEPTH = 8'(MAX_LEN);

    logic [7:0] mem [MAX_LEN];

    // Contents are deliberately unreset; the parser masks reads when no frame is held.
    always_ff @(posedge clk)
        if (we && waddr < DEPTH) mem[waddr[AW-1:0]] <= wdata;

    assign rdata = (raddr < DEPTH) ? mem[raddr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: hunts for SYNC, collects a length-prefixed payload, checks the
// modular checksum and holds the validated frame until the consumer acknowledges it.
//   clk, reset (async, active-low)
//   rx_data/rx_valid       : received byte and its one-cycle strobe
//   frame_valid/frame_len  : held frame flag and payload length
//   rd_addr/rd_data        : combinational payload read, gated by frame_valid and frame_len
//   frame_ack              : consumer releases the held frame
//   len_err/chk_err/to_err/overrun : one-cycle error pulses
module uart_rx_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       frame_valid,
    output logic [7:0] frame_len,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       frame_ack,
    output logic       len_err,
    output logic       chk_err,
    output logic       to_err,
    output logic       overrun
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MAXL    = 8'(MAX_LEN);

    frame_state_t  state;
    logic [7:0]    len;
    logic [7:0]    sum;
    logic [7:0]    idx;
    logic [TW-1:0] cnt;
    logic          in_frame;
    logic          timeout;
    logic          buf_we;
    logic [7:0]    buf_rd;

    assign in_frame = state inside {ST_LEN, ST_PAYLOAD, ST_CHK};
    // Fires on the TIMEOUT-th consecutive strobe-free cycle; a strobe on that cycle wins.
    assign timeout  = in_frame && !rx_valid && cnt == TO_LAST;
    assign buf_we   = rx_valid && state == ST_PAYLOAD;

    uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rdata (buf_rd)
    );

    assign rd_data = (frame_valid && rd_addr < frame_len) ? buf_rd : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            len         <= '0;
            sum         <= '0;
            idx         <= '0;
            cnt         <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            len_err     <= 1'b0;
            chk_err     <= 1'b0;
            to_err      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            len_err <= 1'b0;
            chk_err <= 1'b0;
            to_err  <= 1'b0;
            overrun <= 1'b0;
            cnt     <= (in_frame && !rx_valid && !timeout) ? cnt + 1'b1 : '0;
            if (timeout) begin
                to_err <= 1'b1;
                state  <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:
                        if (rx_valid && rx_data == SYNC) state <= ST_LEN;
                    ST_LEN:
                        if (rx_valid) begin
                            if (rx_data == 8'h00 || rx_data > MAXL) begin
                                len_err <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                len   <= rx_data;
                                sum   <= rx_data;
                                idx   <= '0;
                                state <= ST_PAYLOAD;
                            end
                        end
                    ST_PAYLOAD:
                        if (rx_valid) begin
                            sum <= chk_add(sum, rx_data);
                            idx <= idx + 8'd1;
                            if (idx == len - 8'd1) state <= ST_CHK;
                        end
                    ST_CHK:
                        if (rx_valid) begin
                            if (chk_add(sum, rx_data) == 8'h00) begin
                                frame_valid <= 1'b1;
                                frame_len   <= len;
                                state       <= ST_HOLD;
                            end else begin
                                chk_err <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                    ST_HOLD: begin
                        overrun <= rx_valid;
                        if (frame_ack) begin
                            frame_valid <= 1'b0;
                            frame_len   <= '0;
                            state       <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
